// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  // EX operand mux select: register file, MEM-stage result, WB-stage result.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Multiplier/divider occupancy state.
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Busy counter width; holds latencies 1..15.
  localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle between the datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: stall_*/bubble_ex/flush_if are the pipeline's hold controls.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_mdu_op;
  logic              id_hilo_rd;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              ex_br_taken;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall_pc;
  logic              stall_id;
  logic              bubble_ex;
  logic              flush_if;
  logic              pc_sel;
  logic              mdu_busy;
  logic              mdu_done;

  // Pipeline datapath side.
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_op, id_hilo_rd,
    output ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, ex_br_taken,
    input  fwd_a_sel, fwd_b_sel, stall_pc, stall_id, bubble_ex, flush_if,
    input  pc_sel, mdu_busy, mdu_done
  );

  // Hazard controller side.
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_op, id_hilo_rd,
    input  ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, ex_br_taken,
    output fwd_a_sel, fwd_b_sel, stall_pc, stall_id, bubble_ex, flush_if,
    output pc_sel, mdu_busy, mdu_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// MDU occupancy timer: busy for exactly MDU_LAT cycles after an issue.
// Latency: busy rises the cycle after issue; done marks the last busy cycle.
// Backpressure: none; the caller must not issue while busy (except on done).
module mdu_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic issue,
  output logic busy,
  output logic done
);

  localparam logic [MDU_CNT_W-1:0] CNT_INIT = MDU_CNT_W'(MDU_LAT);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);

  mdu_state_e             state_q;
  logic [MDU_CNT_W-1:0]   count_q;

  // State and down-counter; an issue on the final busy cycle restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (issue) begin
            state_q <= MDU_BUSY;
            count_q <= CNT_INIT;
          end
        end
        MDU_BUSY: begin
          if (count_q == CNT_ONE) begin
            if (issue) begin
              count_q <= CNT_INIT;
            end else begin
              state_q <= MDU_IDLE;
              count_q <= '0;
            end
          end else begin
            count_q <= count_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign busy = (state_q == MDU_BUSY);
  assign done = busy && (count_q == CNT_ONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding control for a 5-stage pipeline: forward selects, stalls, branch redirect.
// Latency: forward selects registered (decided in ID, valid in EX); stall/flush combinational.
// Backpressure: load-use or MDU hazard holds PC and IF/ID and bubbles ID/EX.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int REG_AW  = 5
) (
  input logic               clk,
  input logic               resetn,
  pipe_hazard_ctrl_if.slave bus
);

  // Youngest producer wins: EX (will sit in MEM) beats MEM (will sit in WB).
  // $0 is never forwarded; WB-vs-ID needs nothing since the regfile writes first.
  function automatic fwd_sel_e fwd_pick(
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] ex_rd,
    input logic              ex_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic              mem_we
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (use_src && ex_we && (ex_rd != '0) && (ex_rd == src)) begin
      sel = FWD_MEM;
    end else if (use_src && mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  logic     haz_ld;
  logic     haz_mdu;
  logic     stall;
  logic     mdu_issue;
  logic     mdu_busy_w;
  logic     mdu_done_w;
  fwd_sel_e fwd_a_d;
  fwd_sel_e fwd_a_q;
  fwd_sel_e fwd_b_d;
  fwd_sel_e fwd_b_q;

  assign haz_ld = bus.ex_memread && (bus.ex_rd != '0) &&
                  ((bus.id_use_rs && (bus.ex_rd == bus.id_rs)) ||
                   (bus.id_use_rt && (bus.ex_rd == bus.id_rt)));

  // The MDU result is available on its final busy cycle, so done releases the stall.
  assign haz_mdu   = mdu_busy_w && !mdu_done_w && (bus.id_mdu_op || bus.id_hilo_rd);
  assign stall     = haz_ld || haz_mdu;
  assign mdu_issue = bus.id_mdu_op && !stall;

  mdu_busy_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk    (clk),
    .resetn (resetn),
    .issue  (mdu_issue),
    .busy   (mdu_busy_w),
    .done   (mdu_done_w)
  );

  // Next forward selects: a bubble entering EX must not forward anything.
  always_comb begin
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (!stall) begin
      fwd_a_d = fwd_pick(bus.id_use_rs, bus.id_rs, bus.ex_rd, bus.ex_regwrite,
                         bus.mem_rd, bus.mem_regwrite);
      fwd_b_d = fwd_pick(bus.id_use_rt, bus.id_rt, bus.ex_rd, bus.ex_regwrite,
                         bus.mem_rd, bus.mem_regwrite);
    end
  end

  // Forward select registers move with ID/EX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;
  assign bus.stall_id  = stall;
  assign bus.bubble_ex = stall;
  // A taken branch still redirects the PC under stall; the held IF/ID keeps the delay slot.
  assign bus.stall_pc  = stall && !bus.ex_br_taken;
  assign bus.pc_sel    = bus.ex_br_taken;
  assign bus.flush_if  = bus.ex_br_taken && !stall;
  assign bus.mdu_busy  = mdu_busy_w;
  assign bus.mdu_done  = mdu_done_w;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;

  logic clk;
  logic resetn;

  pipe_hazard_ctrl_if #(.REG_AW(5)) bus ();

  pipe_hazard_ctrl #(
    .MDU_LAT (MDU_LAT),
    .REG_AW  (5)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // MDU occupancy is tracked as "the cycle number of the last issue";
  // busy covers the MDU_LAT cycles that follow it.
  int        cyc       = 0;
  int        issue_cyc = -100;
  logic [1:0] exp_a    = 2'b00;
  logic [1:0] exp_b    = 2'b00;

  function automatic bit m_busy();
    return resetn && (issue_cyc >= 0) && (cyc > issue_cyc) && (cyc <= issue_cyc + MDU_LAT);
  endfunction

  function automatic bit m_done();
    return m_busy() && (cyc == issue_cyc + MDU_LAT);
  endfunction

  function automatic bit m_stall();
    bit ld;
    bit md;
    ld = bus.ex_memread && (bus.ex_rd != 0) &&
         ((bus.id_use_rs && bus.ex_rd == bus.id_rs) || (bus.id_use_rt && bus.ex_rd == bus.id_rt));
    md = m_busy() && !m_done() && (bus.id_mdu_op || bus.id_hilo_rd);
    return ld || md;
  endfunction

  function automatic logic [1:0] m_pick(input bit use_src, input logic [4:0] src);
    if (!use_src) return 2'b00;
    if (bus.ex_regwrite && bus.ex_rd != 0 && bus.ex_rd == src) return 2'b01;
    if (bus.mem_regwrite && bus.mem_rd != 0 && bus.mem_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      exp_a     = 2'b00;
      exp_b     = 2'b00;
      issue_cyc = -100;
    end else begin
      if (m_stall()) begin
        exp_a = 2'b00;
        exp_b = 2'b00;
      end else begin
        exp_a = m_pick(bus.id_use_rs, bus.id_rs);
        exp_b = m_pick(bus.id_use_rt, bus.id_rt);
        if (bus.id_mdu_op) issue_cyc = cyc;
      end
    end
    cyc++;
  end

  always @(negedge resetn) begin
    exp_a     = 2'b00;
    exp_b     = 2'b00;
    issue_cyc = -100;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cmp_stall_id",  bus.stall_id,  m_stall());
    check("cmp_bubble_ex", bus.bubble_ex, m_stall());
    check("cmp_stall_pc",  bus.stall_pc,  m_stall() && !bus.ex_br_taken);
    check("cmp_flush_if",  bus.flush_if,  bus.ex_br_taken && !m_stall());
    check("cmp_pc_sel",    bus.pc_sel,    bus.ex_br_taken);
    check("cmp_mdu_busy",  bus.mdu_busy,  m_busy());
    check("cmp_mdu_done",  bus.mdu_done,  m_done());
    check("cmp_fwd_a",     bus.fwd_a_sel, exp_a);
    check("cmp_fwd_b",     bus.fwd_b_sel, exp_b);
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_mdu_op = 0; bus.id_hilo_rd = 0;
    bus.ex_rd = 0; bus.ex_regwrite = 0; bus.ex_memread = 0;
    bus.mem_rd = 0; bus.mem_regwrite = 0; bus.ex_br_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    #2;
    check("rst_fwd_a", bus.fwd_a_sel, 2'b00);
    check("rst_fwd_b", bus.fwd_b_sel, 2'b00);
    check("rst_busy",  bus.mdu_busy,  1'b0);
    check("rst_done",  bus.mdu_done,  1'b0);
    #10 resetn = 1'b1;
    step();

    // 1: ALU producer in EX feeds rs
    bus.ex_rd = 3; bus.ex_regwrite = 1; bus.id_rs = 3; bus.id_use_rs = 1;
    #1 check("t1_nostall", bus.stall_id, 1'b0);
    step(); idle();
    #1 check("t1_fwd_a", bus.fwd_a_sel, 2'b01);

    // 2: load-use on rt, then the load is in MEM
    bus.ex_rd = 5; bus.ex_regwrite = 1; bus.ex_memread = 1; bus.id_rt = 5; bus.id_use_rt = 1;
    #1;
    check("t2_stall_id",  bus.stall_id,  1'b1);
    check("t2_bubble_ex", bus.bubble_ex, 1'b1);
    check("t2_stall_pc",  bus.stall_pc,  1'b1);
    step(); idle();
    bus.mem_rd = 5; bus.mem_regwrite = 1; bus.id_rt = 5; bus.id_use_rt = 1;
    #1;
    check("t2_released", bus.stall_id, 1'b0);
    check("t2_bubble_fwd", bus.fwd_b_sel, 2'b00);
    step(); idle();
    #1 check("t2_fwd_b_wb", bus.fwd_b_sel, 2'b10);

    // 3: $0 never forwards or stalls
    bus.ex_rd = 0; bus.ex_regwrite = 1; bus.ex_memread = 1; bus.mem_rd = 0; bus.mem_regwrite = 1;
    bus.id_use_rs = 1; bus.id_use_rt = 1;
    #1 check("t3_nostall", bus.stall_id, 1'b0);
    step(); idle();
    #1;
    check("t3_fwd_a", bus.fwd_a_sel, 2'b00);
    check("t3_fwd_b", bus.fwd_b_sel, 2'b00);

    // EX beats MEM; unused rt ignored
    bus.ex_rd = 7; bus.ex_regwrite = 1; bus.mem_rd = 7; bus.mem_regwrite = 1;
    bus.id_rs = 7; bus.id_use_rs = 1; bus.id_rt = 7; bus.id_use_rt = 0;
    step(); idle();
    #1;
    check("prio_fwd_a", bus.fwd_a_sel, 2'b01);
    check("prio_fwd_b", bus.fwd_b_sel, 2'b00);
    // MEM only (EX not writing)
    bus.ex_rd = 6; bus.mem_rd = 6; bus.mem_regwrite = 1; bus.id_rt = 6; bus.id_use_rt = 1;
    step(); idle();
    #1 check("mem_fwd_b", bus.fwd_b_sel, 2'b10);

    // 4: mult at t0, mfhi waits in ID
    bus.id_mdu_op = 1;
    #1 check("t4_issue_nostall", bus.stall_id, 1'b0);
    step(); idle(); bus.id_hilo_rd = 1;
    #1;
    check("t4_busy_t1",  bus.mdu_busy, 1'b1);
    check("t4_stall_t1", bus.stall_id, 1'b1);
    step(); check("t4_stall_t2", bus.stall_id, 1'b1);
    step(); check("t4_stall_t3", bus.stall_id, 1'b1);
    step();
    check("t4_busy_t4",  bus.mdu_busy, 1'b1);
    check("t4_done_t4",  bus.mdu_done, 1'b1);
    check("t4_go_t4",    bus.stall_id, 1'b0);
    step(); idle();
    #1 check("t4_idle_t5", bus.mdu_busy, 1'b0);

    // 5: branch with free ID, then branch during an MDU stall
    bus.ex_br_taken = 1;
    #1;
    check("t5_pc_sel", bus.pc_sel, 1'b1);
    check("t5_flush",  bus.flush_if, 1'b1);
    check("t5_nostall", bus.stall_id, 1'b0);
    step(); idle(); bus.id_mdu_op = 1;
    step(); idle(); bus.id_hilo_rd = 1; bus.ex_br_taken = 1;
    #1;
    check("t5s_pc_sel",   bus.pc_sel,   1'b1);
    check("t5s_stall_pc", bus.stall_pc, 1'b0);
    check("t5s_flush",    bus.flush_if, 1'b0);
    check("t5s_stall_id", bus.stall_id, 1'b1);
    step(); bus.ex_br_taken = 0;
    step();
    step(); idle(); bus.id_mdu_op = 1;
    #1;
    check("reissue_done", bus.mdu_done, 1'b1);
    check("reissue_go",   bus.stall_id, 1'b0);
    step(); idle();
    #1 check("reissue_busy", bus.mdu_busy, 1'b1);
    step(); bus.ex_rd = 9; bus.ex_regwrite = 1; bus.id_rs = 9; bus.id_use_rs = 1;
    step(); idle();
    #1 check("t6_fwd_before", bus.fwd_a_sel, 2'b01);

    // 6: asynchronous reset with count==2
    resetn = 1'b0;
    #1;
    check("t6_busy_rst",  bus.mdu_busy,  1'b0);
    check("t6_fwd_rst",   bus.fwd_a_sel, 2'b00);
    check("t6_done_rst",  bus.mdu_done,  1'b0);
    #1 resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_done", bus.mdu_done, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
